// File: rtl/ofdm_tx_pkg.sv
// Shared types and default settings-bus map for the OFDM transmit framing blocks.
package ofdm_tx_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned GAP_W  = 16;

   localparam int unsigned SR_PREAMBLE_ADDR_DEF = 0;
   localparam int unsigned SR_PREAMBLE_DATA_DEF = 1;
   localparam int unsigned SR_GAP_LEN_DEF       = 2;
   localparam int unsigned SR_ENABLE_DEF        = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_GAP      = 2'd3
   } state_t;

   // One output-stream beat as presented to the output register.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              sof;
   } beat_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/preamble_ram.sv
// Preamble sample store: one write port, one synchronous read port; contents are never reset.
module preamble_ram
   import ofdm_tx_pkg::*;
#(
   parameter int unsigned DEPTH = 160,
   parameter int unsigned AW    = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ofdm_preamble_inserter.sv
// Frames a payload stream as preamble + payload + zero gap, with a registered AXI-style output.
module ofdm_preamble_inserter
   import ofdm_tx_pkg::*;
#(
   parameter int unsigned PREAMBLE_LEN     = 160,
   parameter int unsigned SR_PREAMBLE_ADDR = SR_PREAMBLE_ADDR_DEF,
   parameter int unsigned SR_PREAMBLE_DATA = SR_PREAMBLE_DATA_DEF,
   parameter int unsigned SR_GAP_LEN       = SR_GAP_LEN_DEF,
   parameter int unsigned SR_ENABLE        = SR_ENABLE_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic        sof
);

   localparam int unsigned AW    = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam int unsigned PTR_W = (AW > 8) ? AW : 8;
   localparam int unsigned CNT_W = $clog2(max_u(PREAMBLE_LEN, 65535) + 1);

   state_t            state, state_nxt;
   logic              enable, alive;
   logic [GAP_W-1:0]  gap_len, gap_lat;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  pre_idx, gap_cnt;
   logic              ram_vld;
   logic [DATA_W-1:0] ram_rdata;
   logic [AW-1:0]     rd_addr;
   logic              adv, start, rd_en, ram_take, gap_step, load;
   logic              sr_addr_wr, sr_data_wr, ram_we, ptr_wrap;
   beat_t             beat;

   assign adv        = !o_tvalid || o_tready;
   assign sr_addr_wr = set_stb && (set_addr == 8'(SR_PREAMBLE_ADDR));
   assign sr_data_wr = set_stb && (set_addr == 8'(SR_PREAMBLE_DATA));
   assign ram_we     = sr_data_wr && (state == ST_IDLE) && (32'(wr_ptr) < PREAMBLE_LEN);
   assign ptr_wrap   = (32'(wr_ptr) >= PREAMBLE_LEN - 1);

   preamble_ram #(
      .DEPTH (PREAMBLE_LEN),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (AW'(wr_ptr)),
      .wdata (set_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next state plus the per-cycle datapath controls; ram_vld means ram_rdata holds sample pre_idx-1.
   always_comb begin
      state_nxt = state;
      i_tready  = 1'b0;
      start     = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      ram_take  = 1'b0;
      gap_step  = 1'b0;
      load      = 1'b0;
      beat      = '0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               if (i_tvalid) begin
                  start     = 1'b1;
                  rd_en     = 1'b1;
                  state_nxt = ST_PREAMBLE;
               end
            end else begin
               i_tready = alive && adv;
               if (i_tready && i_tvalid) begin
                  load = 1'b1;
                  beat = '{data: i_tdata, last: i_tlast, sof: 1'b0};
               end
            end
         end
         ST_PREAMBLE: begin
            ram_take = adv && ram_vld;
            rd_en    = (32'(pre_idx) < PREAMBLE_LEN) && (!ram_vld || adv);
            rd_addr  = AW'(pre_idx);
            if (ram_take) begin
               load = 1'b1;
               beat = '{data: ram_rdata, last: 1'b0, sof: (pre_idx == CNT_W'(1))};
               if (32'(pre_idx) == PREAMBLE_LEN) state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            i_tready = adv;
            if (adv && i_tvalid) begin
               load = 1'b1;
               beat = '{data: i_tdata, last: i_tlast && (gap_lat == '0), sof: 1'b0};
               if (i_tlast) state_nxt = (gap_lat != '0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (adv) begin
               load     = 1'b1;
               gap_step = 1'b1;
               beat     = '{data: '0, last: (gap_cnt == CNT_W'(gap_lat) - CNT_W'(1)), sof: 1'b0};
               if (beat.last) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output register: loads on advance, holds everything while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
         sof      <= 1'b0;
         o_tdata  <= '0;
      end else if (adv) begin
         o_tvalid <= load;
         o_tlast  <= load && beat.last;
         sof      <= load && beat.sof;
         if (load) o_tdata <= beat.data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_idx <= '0;
         ram_vld <= 1'b0;
         gap_lat <= '0;
         gap_cnt <= '0;
      end else begin
         if (start)      pre_idx <= CNT_W'(1);
         else if (rd_en) pre_idx <= pre_idx + CNT_W'(1);
         if (rd_en)         ram_vld <= 1'b1;
         else if (ram_take) ram_vld <= 1'b0;
         if (start) begin
            gap_lat <= gap_len;
            gap_cnt <= '0;
         end else if (gap_step) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
         end
      end
   end

   // Settings registers; preamble writes outside IDLE are dropped without moving the pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alive   <= 1'b0;
         enable  <= 1'b0;
         gap_len <= '0;
         wr_ptr  <= '0;
      end else begin
         alive <= 1'b1;
         if (set_stb && (set_addr == 8'(SR_ENABLE)))  enable  <= set_data[0];
         if (set_stb && (set_addr == 8'(SR_GAP_LEN))) gap_len <= set_data[GAP_W-1:0];
         if (sr_addr_wr)
            wr_ptr <= PTR_W'(set_data[7:0]);
         else if (sr_data_wr && (state == ST_IDLE))
            wr_ptr <= ptr_wrap ? '0 : wr_ptr + PTR_W'(1);
      end
   end

endmodule
